// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serial transmit framer. Bytes arrive over a valid/ready handshake into a
//   one-entry holding register, are copied into a shifter when the line is
//   free, and go out LSB-first framed by a programmable number of start and
//   stop bits. Everything runs on UART_CLK; any clock-domain crossing is
//   done upstream.
//
// Ports
//   UART_CLK    clock, all state updates on the rising edge
//   RESET       asynchronous, active-low reset
//   TX_DATA     byte to send, captured when TX_VALID && TX_READY
//   TX_VALID    upstream offers TX_DATA
//   TX_READY    holding register empty
//   START_BITS  start bits per frame (0 behaves as 1), latched at load
//   STOP_BITS   stop bits per frame (0 behaves as 1), latched at load
//   UART_OUT    serial line, idles high
//   TX_BUSY     a frame is being shifted out
//   TX_DONE     one-cycle pulse during the last cycle of the last stop bit
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 UART_CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  input  logic [3:0]           START_BITS,
  input  logic [3:0]           STOP_BITS,
  output logic                 UART_OUT,
  output logic                 TX_BUSY,
  output logic                 TX_DONE
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_LAST   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] BAUD_PENULT = 8'((CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0);
  localparam bit         SINGLE_CLK  = (CLKS_PER_BIT == 1);
  localparam logic [5:0] DATA_LAST   = 6'(DATA_BITS - 1);
  localparam int         NEXT_IDX    = (DATA_BITS > 1) ? 1 : 0;

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shifter;
  logic                 hold_full;
  logic                 ready;
  logic [3:0]           start_len;
  logic [3:0]           stop_len;
  logic [7:0]           baud_cnt;
  logic [5:0]           bit_cnt;
  logic                 line;
  logic                 busy;
  logic                 done;

  logic [3:0] start_eff;
  logic [3:0] stop_eff;
  logic       bit_end;
  logic       start_last;
  logic       stop_last_bit;
  logic       frame_end;
  logic       load;
  logic       accept;

  assign start_eff     = (START_BITS == 4'd0) ? 4'd1 : START_BITS;
  assign stop_eff      = (STOP_BITS  == 4'd0) ? 4'd1 : STOP_BITS;
  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign start_last    = (bit_cnt == {2'b00, start_len} - 6'd1);
  assign stop_last_bit = (bit_cnt == {2'b00, stop_len} - 6'd1);
  assign frame_end     = (state == STOP) && bit_end && stop_last_bit;
  // Load either from idle or on the very edge that ends the previous frame,
  // which gives back-to-back frames with no idle gap.
  assign load          = hold_full && ((state == IDLE) || frame_end);
  assign accept        = TX_VALID && ready;

  assign TX_READY = ready;
  assign UART_OUT = line;
  assign TX_BUSY  = busy;
  assign TX_DONE  = done;

  always_ff @(posedge UART_CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      hold      <= '0;
      shifter   <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b1;
      start_len <= 4'd1;
      stop_len  <= 4'd1;
      baud_cnt  <= 8'd0;
      bit_cnt   <= 6'd0;
      line      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Holding register: load and accept are mutually exclusive because
      // ready is low whenever hold_full is set.
      if (load) begin
        hold_full <= 1'b0;
        ready     <= 1'b1;
      end else if (accept) begin
        hold      <= TX_DATA;
        hold_full <= 1'b1;
        ready     <= 1'b0;
      end

      if (load) begin
        shifter   <= hold;
        start_len <= start_eff;
        stop_len  <= stop_eff;
        state     <= START;
        line      <= 1'b0;
        busy      <= 1'b1;
        baud_cnt  <= 8'd0;
        bit_cnt   <= 6'd0;
      end else begin
        case (state)
          IDLE: begin
            line <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              baud_cnt <= 8'd0;
              if (start_last) begin
                state   <= DATA;
                bit_cnt <= 6'd0;
                line    <= shifter[0];
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end else begin
              baud_cnt <= baud_cnt + 8'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= 8'd0;
              shifter  <= shifter >> 1;
              if (bit_cnt == DATA_LAST) begin
                state   <= STOP;
                bit_cnt <= 6'd0;
                line    <= 1'b1;
                // With one clock per bit the first stop cycle may already be
                // the last cycle of the frame.
                done    <= SINGLE_CLK && (stop_len == 4'd1);
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                line    <= shifter[NEXT_IDX];
              end
            end else begin
              baud_cnt <= baud_cnt + 8'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              baud_cnt <= 8'd0;
              if (stop_last_bit) begin
                state <= IDLE;
                busy  <= 1'b0;
                line  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                done    <= SINGLE_CLK && ({2'b00, stop_len} == bit_cnt + 6'd2);
              end
            end else begin
              baud_cnt <= baud_cnt + 8'd1;
              // done is registered, so it is raised one cycle early to land
              // on the final cycle of the last stop bit.
              done     <= !SINGLE_CLK && (baud_cnt == BAUD_PENULT) && stop_last_bit;
            end
          end
          default: begin
            state <= IDLE;
            line  <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       UART_CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [3:0] START_BITS = 4'd1;
  logic [3:0] STOP_BITS = 4'd1;
  logic       UART_OUT;
  logic       TX_BUSY;
  logic       TX_DONE;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic line;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  always #5 UART_CLK = ~UART_CLK;

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
    .UART_CLK   (UART_CLK),
    .RESET      (RESET),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .START_BITS (START_BITS),
    .STOP_BITS  (STOP_BITS),
    .UART_OUT   (UART_OUT),
    .TX_BUSY    (TX_BUSY),
    .TX_DONE    (TX_DONE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle line/busy/done for one whole frame.
  task automatic push_frame(input logic [7:0] b, input int s, input int p);
    exp_t e;
    int total;
    int n;
    total = (s + 8 + p) * CPB;
    n = 0;
    for (int i = 0; i < s * CPB; i++) begin
      e = '{line: 1'b0, busy: 1'b1, done: (n == total - 1)};
      exp_q.push_back(e);
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < CPB; k++) begin
        e = '{line: b[i], busy: 1'b1, done: (n == total - 1)};
        exp_q.push_back(e);
        n++;
      end
    end
    for (int i = 0; i < p * CPB; i++) begin
      e = '{line: 1'b1, busy: 1'b1, done: (n == total - 1)};
      exp_q.push_back(e);
      n++;
    end
  endtask

  // One clock: sample outputs at the falling edge against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge UART_CLK);
    cyc++;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{line: 1'b1, busy: 1'b0, done: 1'b0};
    check($sformatf("line@%0d", cyc), UART_OUT, e.line);
    check($sformatf("busy@%0d", cyc), TX_BUSY, e.busy);
    check($sformatf("done@%0d", cyc), TX_DONE, e.done);
  endtask

  // Offer a byte to an idle, empty block: accepted on the next edge, line
  // drops one edge later.
  task automatic offer(input logic [7:0] b, input int s, input int p);
    exp_t e;
    e = '{line: 1'b1, busy: 1'b0, done: 1'b0};
    exp_q.push_back(e);
    push_frame(b, s, p);
    TX_DATA  = b;
    TX_VALID = 1'b1;
    step();
    check("ready_after_accept", TX_READY, 1'b0);
    TX_VALID = 1'b0;
    $display("tx byte=%02h start=%0d stop=%0d at cycle %0d", b, s, p, cyc);
  endtask

  initial begin
    // Reset held low with random inputs.
    for (int i = 0; i < 6; i++) begin
      TX_VALID   = 1'($urandom_range(0, 1));
      TX_DATA    = 8'($urandom);
      START_BITS = 4'($urandom);
      STOP_BITS  = 4'($urandom);
      step();
      check("ready_in_reset", TX_READY, 1'b1);
    end
    TX_VALID   = 1'b0;
    START_BITS = 4'd1;
    STOP_BITS  = 4'd1;
    RESET      = 1'b1;
    repeat (2) step();
    check("ready_after_reset", TX_READY, 1'b1);

    // Single byte 0xA5, 1 start / 1 stop.
    offer(8'hA5, 1, 1);
    repeat (40) step();
    step();
    check("ready_after_single", TX_READY, 1'b1);

    // Back-to-back 0x55 then 0x0F.
    offer(8'h55, 1, 1);
    push_frame(8'h0F, 1, 1);
    TX_DATA  = 8'h0F;
    TX_VALID = 1'b1;
    step();
    check("b2b_ready_after_load", TX_READY, 1'b1);
    step();
    check("b2b_ready_after_accept", TX_READY, 1'b0);
    TX_VALID = 1'b0;
    $display("tx byte=0f start=1 stop=1 at cycle %0d (queued behind 55)", cyc);
    repeat (37) step();
    check("b2b_ready_frame1_end", TX_READY, 1'b0);
    step();
    step();
    check("b2b_ready_frame2_start", TX_READY, 1'b1);
    repeat (42) step();

    // Configuration extremes.
    START_BITS = 4'd3;
    STOP_BITS  = 4'd2;
    offer(8'h00, 3, 2);
    repeat (53) step();
    START_BITS = 4'd0;
    STOP_BITS  = 4'd0;
    offer(8'hA5, 1, 1);
    repeat (41) step();

    // Mid-frame STOP_BITS change affects only the next frame.
    START_BITS = 4'd1;
    STOP_BITS  = 4'd1;
    offer(8'h3C, 1, 1);
    push_frame(8'h81, 1, 4);
    TX_DATA  = 8'h81;
    TX_VALID = 1'b1;
    step();
    step();
    TX_VALID = 1'b0;
    $display("tx byte=81 start=1 stop=4 at cycle %0d (queued behind 3c)", cyc);
    repeat (10) step();
    STOP_BITS = 4'd4;
    repeat (28) step();
    repeat (53) step();
    STOP_BITS = 4'd1;

    // Reset during data bit 3 with a second byte held.
    offer(8'hC3, 1, 1);
    TX_DATA  = 8'h7E;
    TX_VALID = 1'b1;
    step();
    step();
    TX_VALID = 1'b0;
    check("held_before_reset", TX_READY, 1'b0);
    repeat (16) step();
    #2 RESET = 1'b0;
    #1;
    check("async_line", UART_OUT, 1'b1);
    check("async_busy", TX_BUSY, 1'b0);
    check("async_ready", TX_READY, 1'b1);
    check("async_done", TX_DONE, 1'b0);
    exp_q.delete();
    $display("reset asserted mid-frame at cycle %0d", cyc);
    repeat (3) step();
    RESET = 1'b1;
    repeat (50) step();
    check("ready_after_abort", TX_READY, 1'b1);
    offer(8'h96, 1, 1);
    repeat (41) step();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial transmit stage directly downstream of the PCI target write path. It accepts bytes over a valid/ready handshake into a one-entry holding register, frames each byte with a programmable number of start and stop bits, and shifts it out LSB-first on UART_OUT. The block runs entirely in the UART_CLK domain. Any PCI-to-UART domain crossing happens upstream of it.

Parameters:
DATA_BITS, 8, data bits per frame; must match the TX_DATA width.
CLKS_PER_BIT, 4, UART_CLK cycles per serial bit; legal range 1..255.

Ports:
UART_CLK  input  1  single clock for the block; all state updates on its rising edge
RESET  input  1  asynchronous, active-low reset
TX_DATA  input  DATA_BITS  byte to transmit; sampled on accept
TX_VALID  input  1  upstream has a byte on TX_DATA
TX_READY  output  1  holding register empty; a byte can be accepted
START_BITS  input  4  start bits per frame; 0 is treated as 1
STOP_BITS  input  4  stop bits per frame; 0 is treated as 1
UART_OUT  output  1  serial line; idles high
TX_BUSY  output  1  a frame is in progress
TX_DONE  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset (RESET low, asynchronous): UART_OUT=1, TX_READY=1, TX_BUSY=0, TX_DONE=0. Holding register and shifter are emptied, the FSM goes to IDLE and all counters clear. Reset mid-frame aborts the frame: the line goes high immediately and no partial frame resumes after release.
- Accept: when TX_VALID=1 and TX_READY=1 on a rising edge, TX_DATA is captured into the holding register and hold_full is set.
- TX_READY is exactly !hold_full (registered). It does not rise combinationally in the cycle the shifter loads.
- Load:
  - In IDLE with hold_full=1, the next edge copies hold into the shifter, clears hold_full, and latches START_BITS/STOP_BITS (0 maps to 1).
  - The FSM then enters START and TX_BUSY=1.
  - Latency: a byte accepted at edge N into an empty, idle block drives UART_OUT low from edge N+1.
- FSM states:
  - IDLE: UART_OUT=1.
  - START: UART_OUT=0 for S*CLKS_PER_BIT cycles.
  - DATA: UART_OUT = shifter LSB; the shifter shifts right every CLKS_PER_BIT cycles, for DATA_BITS bits.
  - STOP: UART_OUT=1 for P*CLKS_PER_BIT cycles.
- Counters: a baud counter counts 0..CLKS_PER_BIT-1. A bit counter is 6 bits wide and covers a maximum of 15+8+15=38 bits. Both clear on every state entry.
- End of frame:
  - On the last cycle of the last stop bit, TX_DONE=1 for exactly one cycle.
  - If hold_full=1, the shifter reloads on that same edge and START follows with zero idle cycles (back-to-back frames).
  - Otherwise the FSM returns to IDLE and TX_BUSY=0.
- Frame length: (S + DATA_BITS + P) * CLKS_PER_BIT cycles.
- Configuration: changes to START_BITS/STOP_BITS mid-frame have no effect until the next load.
- Simultaneous accept and load: not possible; TX_READY=0 whenever hold_full=1. Hold refills at the earliest on the edge after a load.
- Upstream may deassert TX_VALID at any time. No byte is ever dropped or duplicated.

Test Plan:
- Reset: hold RESET low with random inputs -> UART_OUT=1, TX_READY=1, TX_BUSY=0, TX_DONE=0 throughout.
- Single byte: 0xA5 with START=1, STOP=1, CLKS_PER_BIT=4 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 total); TX_DONE pulses once on cycle 40; TX_BUSY falls after.
- Back-to-back: 0x55, then 0x0F offered continuously -> 0x0F accepted 1 cycle after the first load; TX_READY low until the end of the first frame; second start bit begins immediately after the first stop bit with no idle gap; two TX_DONE pulses 40 cycles apart.
- Config extremes: START=3, STOP=2, byte 0x00 -> 44 low cycles then 8 high, TX_DONE at cycle 52. START=0, STOP=0 -> identical to START=1, STOP=1.
- Reset mid-frame: assert RESET during data bit 3 with a byte also held -> UART_OUT high asynchronously; after release TX_READY=1, no frame is emitted, and a new byte transmits correctly.
- Mid-frame config change: change STOP_BITS from 1 to 4 during the DATA state -> current frame keeps 1 stop bit; next frame uses 4.
